// File: rtl/sio_pkg.sv
// Shared lad mode encoding and FSM state enumeration for serial_io_bridge.
package sio_pkg;

    typedef enum logic [1:0] {
        LadIdle = 2'b00,
        LadAddr = 2'b01,
        LadData = 2'b10,
        LadRead = 2'b11
    } lad_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadD,
        StRdWait,
        StRdShift,
        StDone
    } sio_state_e;

endpackage

// File: rtl/sio_shift_in.sv
// LSB-first serial shifter: accepts N bits, keeps the first W in data_o, then stops.
module sio_shift_in #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = W,
    parameter int unsigned CntW = $clog2(N + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         sdi_i,
    output logic [W-1:0] data_o,
    output logic         last_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic            done;

    // Counter saturates at N so it can never wrap back into a shifting window.
    assign done = (cnt_q == CntW'(N));

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !done) begin
            if (cnt_q < CntW'(W)) begin
                data_d = {sdi_i, data_q[W-1:1]};
            end
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign last_o = en_i && !clr_i && (cnt_q == CntW'(N - 1));

endmodule

// File: rtl/serial_io_bridge.sv
// Serial address/data loader and register-file read serializer.
// Define SIO_PARITY_EN to add an even-parity bit to data loads and read-outs.
module serial_io_bridge
    import sio_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [1:0]        lad,
    input  logic              sdi,
    output logic [ADDR_W-1:0] addr_reg,
    output logic [DATA_W-1:0] din_reg,
    output logic              wr_en,
    output logic              rd_req,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CntW  = $clog2(DATA_W + 2);
    localparam int unsigned ACntW = $clog2(ADDR_W + 2);
`ifdef SIO_PARITY_EN
    localparam int unsigned DataBits = DATA_W + 1;
`else
    localparam int unsigned DataBits = DATA_W;
`endif

    sio_state_e        state_q, state_d;
    lad_e              mode_q, mode_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic              err_q, err_d;
    logic              a_en, d_en, a_last, d_last, shift_clr;

    assign shift_clr = (state_q == StIdle);

    sio_shift_in #(
        .W    (ADDR_W),
        .N    (ADDR_W),
        .CntW (ACntW)
    ) u_addr_shift (
        .clk_i  (clk1),
        .rst_ni (rst),
        .clr_i  (shift_clr),
        .en_i   (a_en),
        .sdi_i  (sdi),
        .data_o (addr_reg),
        .last_o (a_last)
    );

    sio_shift_in #(
        .W    (DATA_W),
        .N    (DataBits),
        .CntW (CntW)
    ) u_data_shift (
        .clk_i  (clk1),
        .rst_ni (rst),
        .clr_i  (shift_clr),
        .en_i   (d_en),
        .sdi_i  (sdi),
        .data_o (din_reg),
        .last_o (d_last)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cap_d    = cap_q;
        rd_cnt_d = rd_cnt_q;
        wr_en_d  = 1'b0;
        err_d    = 1'b0;
        a_en     = 1'b0;
        d_en     = 1'b0;

        if (state_q == StIdle) begin
            rd_cnt_d = '0;
            mode_d   = lad_e'(lad);
            unique case (lad)
                LadIdle: state_d = StIdle;
                LadAddr: state_d = StLoadA;
                LadData: state_d = StLoadD;
                LadRead: state_d = StRdWait;
            endcase
        end else if (lad == LadIdle) begin
            state_d = StIdle;
        end else if (lad != mode_q) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                StLoadA: begin
                    a_en = 1'b1;
                    if (a_last) state_d = StDone;
                end
                StLoadD: begin
                    d_en = 1'b1;
                    if (d_last) begin
                        state_d = StDone;
`ifdef SIO_PARITY_EN
                        // Final bit is the even-parity bit; din_reg is already complete here.
                        if (sdi == ^din_reg) wr_en_d = 1'b1;
                        else                 err_d   = 1'b1;
`else
                        wr_en_d = 1'b1;
`endif
                    end
                end
                StRdWait: begin
                    if (rd_ack) begin
                        cap_d    = rd_data;
                        rd_cnt_d = '0;
                        state_d  = StRdShift;
                    end
                end
                StRdShift: begin
                    if (rd_cnt_q == CntW'(DataBits - 1)) state_d = StDone;
                    else                                 rd_cnt_d = rd_cnt_q + CntW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            mode_q   <= LadIdle;
            cap_q    <= '0;
            rd_cnt_q <= '0;
            wr_en_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cap_q    <= cap_d;
            rd_cnt_q <= rd_cnt_d;
            wr_en_q  <= wr_en_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        sdo       = 1'b0;
        sdo_valid = 1'b0;
        if (state_q == StRdShift) begin
            sdo_valid = 1'b1;
            sdo       = 1'(cap_q >> rd_cnt_q);
`ifdef SIO_PARITY_EN
            if (rd_cnt_q == CntW'(DATA_W)) sdo = ^cap_q;
`endif
        end
    end

    assign wr_en  = wr_en_q;
    assign err    = err_q;
    assign rd_req = (state_q == StRdWait);
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_serial_io_bridge.sv
// Randomized self-checking bench for serial_io_bridge against a word-level reference model.
module tb_serial_io_bridge;

    localparam int AW = 10;
    localparam int DW = 64;

    logic          clk1 = 1'b0;
    logic          rst;
    logic [1:0]    lad;
    logic          sdi;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] din_reg;
    logic          wr_en, rd_req, rd_ack, sdo, sdo_valid, busy, err;
    logic [DW-1:0] rd_data;

    int n_cmp;
    int n_mis;

    logic [AW-1:0] addr_m;
    logic [DW-1:0] din_m;

    serial_io_bridge #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .lad       (lad),
        .sdi       (sdi),
        .addr_reg  (addr_reg),
        .din_reg   (din_reg),
        .wr_en     (wr_en),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick;
        @(negedge clk1);
    endtask

    task automatic test_reset;
        rst = 1'b0; lad = 2'b00; sdi = 1'b0; rd_ack = 1'b0; rd_data = '0;
        #2;
        n_cmp++;
        if ({addr_reg, din_reg, wr_en, rd_req, sdo, sdo_valid, busy, err} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got addr=%h din=%h ctl=%b want all zero", addr_reg,
                     din_reg, {wr_en, rd_req, sdo, sdo_valid, busy, err});
        end
        tick(); rst = 1'b1; tick(); tick();
        n_cmp++;
        if ({wr_en, rd_req, sdo_valid, busy, err} !== 5'b0) begin
            n_mis++;
            $display("FAIL post_reset_idle: got %b want 00000",
                     {wr_en, rd_req, sdo_valid, busy, err});
        end
        addr_m = '0;
        din_m  = '0;
    endtask

    task automatic test_addr_load(input logic [AW-1:0] a, input int extra);
        lad = 2'b01; sdi = 1'($urandom); tick();
        for (int k = 0; k < AW; k++) begin
            sdi = a[k]; tick();
        end
        addr_m = a;
        n_cmp++;
        if (addr_reg !== addr_m || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL addr_load: got addr=%h busy=%b want addr=%h busy=1", addr_reg, busy,
                     addr_m);
        end
        for (int e = 0; e < extra; e++) begin
            sdi = 1'($urandom); tick();
        end
        n_cmp++;
        if (addr_reg !== addr_m || busy !== 1'b1 || err !== 1'b0) begin
            n_mis++;
            $display("FAIL addr_extra_bits: got addr=%h busy=%b err=%b want addr=%h busy=1 err=0",
                     addr_reg, busy, err, addr_m);
        end
        lad = 2'b00; tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL addr_return_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_data_write(input logic [DW-1:0] d, input int hold);
        lad = 2'b10; sdi = 1'($urandom); tick();
        for (int k = 0; k < DW; k++) begin
            sdi = d[k];
            n_cmp++;
            if (wr_en !== 1'b0) begin
                n_mis++;
                $display("FAIL data_early_wr_en: bit %0d got wr_en=%b want 0", k, wr_en);
            end
            tick();
        end
`ifdef SIO_PARITY_EN
        sdi = ^d; tick();
`endif
        din_m = d;
        n_cmp++;
        if (wr_en !== 1'b1 || din_reg !== din_m || err !== 1'b0) begin
            n_mis++;
            $display("FAIL data_write: got wr_en=%b err=%b din=%h want wr_en=1 err=0 din=%h",
                     wr_en, err, din_reg, din_m);
        end
        for (int h = 0; h < hold; h++) begin
            sdi = 1'($urandom); tick();
            n_cmp++;
            if (wr_en !== 1'b0 || din_reg !== din_m || busy !== 1'b1) begin
                n_mis++;
                $display("FAIL data_done_hold: got wr_en=%b busy=%b din=%h want 0 1 %h",
                         wr_en, busy, din_reg, din_m);
            end
        end
        lad = 2'b00; tick();
        n_cmp++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            n_mis++;
            $display("FAIL data_return_idle: got busy=%b wr_en=%b want 0 0", busy, wr_en);
        end
    endtask

    task automatic test_read(input logic [DW-1:0] w, input int lat);
        logic exp_q[$];
        logic exp;
        for (int k = 0; k < DW; k++) exp_q.push_back(1'((w >> k) & 64'd1));
`ifdef SIO_PARITY_EN
        exp_q.push_back(^w);
`endif
        lad = 2'b11; rd_ack = 1'b0; tick();
        n_cmp++;
        if (rd_req !== 1'b1 || sdo_valid !== 1'b0 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL read_req: got rd_req=%b sdo_valid=%b busy=%b want 1 0 1", rd_req,
                     sdo_valid, busy);
        end
        for (int j = 0; j < lat; j++) begin
            tick();
            n_cmp++;
            if (rd_req !== 1'b1) begin
                n_mis++;
                $display("FAIL read_req_held: cycle %0d got rd_req=%b want 1", j, rd_req);
            end
        end
        rd_ack = 1'b1; rd_data = w; tick();
        rd_ack = 1'b0; rd_data = {$urandom, $urandom};
        n_cmp++;
        if (rd_req !== 1'b0) begin
            n_mis++;
            $display("FAIL read_req_drop: got rd_req=%b want 0", rd_req);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({sdo_valid, sdo} !== {1'b1, exp}) begin
                n_mis++;
                $display("FAIL read_sdo: bit %0d got valid=%b sdo=%b want valid=1 sdo=%b", k,
                         sdo_valid, sdo, exp);
            end
            // Stray acks during the shift must not disturb the captured word.
            rd_ack = 1'($urandom); rd_data = {$urandom, $urandom};
            tick();
        end
        rd_ack = 1'b0;
        n_cmp++;
        if ({sdo_valid, sdo} !== 2'b00 || busy !== 1'b1 || rd_req !== 1'b0) begin
            n_mis++;
            $display("FAIL read_done: got valid=%b sdo=%b busy=%b rd_req=%b want 0 0 1 0",
                     sdo_valid, sdo, busy, rd_req);
        end
        lad = 2'b00; tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL read_return_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort(input logic [DW-1:0] d, input int nbits);
        lad = 2'b10; sdi = 1'($urandom); tick();
        for (int k = 0; k < nbits; k++) begin
            sdi = d[k]; tick();
        end
        lad = 2'b00; tick();
        din_m = (din_m >> nbits) | ((d & ((64'd1 << nbits) - 64'd1)) << (DW - nbits));
        n_cmp++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || din_reg !== din_m) begin
            n_mis++;
            $display("FAIL abort_data: got wr_en=%b busy=%b err=%b din=%h want 0 0 0 din=%h",
                     wr_en, busy, err, din_reg, din_m);
        end
    endtask

    task automatic test_mode_err(input logic [AW-1:0] a, input int nbits);
        lad = 2'b01; sdi = 1'($urandom); tick();
        for (int k = 0; k < nbits; k++) begin
            sdi = a[k]; tick();
        end
        lad = 2'b10; tick();
        addr_m = AW'((64'(addr_m) >> nbits) |
                     ((64'(a) & ((64'd1 << nbits) - 64'd1)) << (AW - nbits)));
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0 || addr_reg !== addr_m) begin
            n_mis++;
            $display("FAIL mode_change_err: got err=%b busy=%b wr_en=%b addr=%h want 1 0 0 %h",
                     err, busy, wr_en, addr_reg, addr_m);
        end
        lad = 2'b00; tick();
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL err_one_cycle: got err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    task automatic test_read_abort;
        lad = 2'b11; tick();
        lad = 2'b00; tick();
        n_cmp++;
        if (rd_req !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_mis++;
            $display("FAIL read_abort_idle: got rd_req=%b busy=%b err=%b want 0 0 0", rd_req,
                     busy, err);
        end
        lad = 2'b11; tick();
        lad = 2'b01; tick();
        n_cmp++;
        if (rd_req !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            n_mis++;
            $display("FAIL read_abort_err: got rd_req=%b busy=%b err=%b want 0 0 1", rd_req,
                     busy, err);
        end
        lad = 2'b00; tick();
    endtask

`ifdef SIO_PARITY_EN
    task automatic test_parity;
        for (int p = 0; p < 2; p++) begin
            lad = 2'b10; sdi = 1'($urandom); tick();
            for (int k = 0; k < DW; k++) begin
                sdi = (k == 0); tick();
            end
            sdi = 1'(p); tick();
            din_m = 64'd1;
            n_cmp++;
            if (wr_en !== 1'(p) || err !== 1'(1 - p) || din_reg !== din_m) begin
                n_mis++;
                $display("FAIL parity_check: pbit=%0d got wr_en=%b err=%b din=%h want %0d %0d %h",
                         p, wr_en, err, din_reg, p, 1 - p, din_m);
            end
            lad = 2'b00; tick();
        end
    endtask
`endif

    task automatic test_reset_mid_read(input logic [DW-1:0] w);
        lad = 2'b11; tick(); tick();
        rd_ack = 1'b1; rd_data = w; tick();
        rd_ack = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        n_cmp++;
        if ({sdo_valid, sdo} !== {1'b1, 1'((w >> 30) & 64'd1)}) begin
            n_mis++;
            $display("FAIL reset_read_bit30: got valid=%b sdo=%b want 1 %b", sdo_valid, sdo,
                     1'((w >> 30) & 64'd1));
        end
        rst = 1'b0;
        #1;
        addr_m = '0;
        din_m  = '0;
        n_cmp++;
        if ({addr_reg, din_reg, wr_en, rd_req, sdo, sdo_valid, busy, err} !==
            {addr_m, din_m, 6'b0}) begin
            n_mis++;
            $display("FAIL reset_mid_read: got addr=%h din=%h ctl=%b want all zero", addr_reg,
                     din_reg, {wr_en, rd_req, sdo, sdo_valid, busy, err});
        end
        tick(); lad = 2'b00; rst = 1'b1; tick();
        n_cmp++;
        if (busy !== 1'b0 || sdo_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_release_idle: got busy=%b sdo_valid=%b want 0 0", busy,
                     sdo_valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_addr_load(10'h2A5, 3);
        test_data_write(64'hDEADBEEF_01234567, 3);
        test_read(64'h8000_0000_0000_0001, 3);
        test_abort({$urandom, $urandom}, 20);
        test_mode_err(AW'($urandom), 5);
        test_read_abort();
        for (int i = 0; i < 4; i++) begin
            test_addr_load(AW'($urandom), int'($urandom_range(0, 3)));
            test_data_write({$urandom, $urandom}, int'($urandom_range(1, 3)));
            test_read({$urandom, $urandom}, int'($urandom_range(0, 5)));
            test_abort({$urandom, $urandom}, int'($urandom_range(1, DW - 1)));
            test_mode_err(AW'($urandom), int'($urandom_range(1, AW - 1)));
        end
`ifdef SIO_PARITY_EN
        test_parity();
`endif
        test_data_write({$urandom, $urandom}, 1);
        test_reset_mid_read({$urandom, $urandom});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_io_bridge.md
SERIAL_IO_BRIDGE -- requirements
Module: serial_io_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the address register width.
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the data word width (>=8).
REQ-003 Port clk1  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port lad  input  2  mode: 00 idle/abort, 01 load address, 10 load data, 11 read.
REQ-006 Port sdi  input  1  serial input, LSB first, shared by address and data loads.
REQ-007 Port addr_reg  output  ADDR_W  assembled address.
REQ-008 Port din_reg  output  DATA_W  assembled write data.
REQ-009 Port wr_en  output  1  one-cycle write strobe to the register file.
REQ-010 Port rd_req  output  1  read request to the register file, held until acknowledged.
REQ-011 Port rd_ack  input  1  register file read acknowledge; rd_data valid in this cycle.
REQ-012 Port rd_data  input  DATA_W  register file read word.
REQ-013 Port sdo  output  1  serial output, LSB first.
REQ-014 Port sdo_valid  output  1  high in every cycle sdo carries a payload bit.
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port err  output  1  one-cycle error pulse.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD_A, LOAD_D, RD_WAIT, RD_SHIFT and DONE.
REQ-018 In IDLE, lad 01/10/11 SHALL move the FSM to LOAD_A/LOAD_D/RD_WAIT respectively, and the bit counter SHALL be cleared.
REQ-019 In IDLE, the sdi bit of the entry cycle SHALL NOT be sampled; shifting SHALL start in the first cycle of LOAD_A or LOAD_D.
REQ-020 In LOAD_A, each cycle SHALL perform addr_reg <= {sdi, addr_reg[ADDR_W-1:1]}; after ADDR_W bits the FSM SHALL enter DONE, and no further bits SHALL be shifted.
REQ-021 LOAD_D SHALL shift din_reg the same way; after DATA_W bits, wr_en SHALL pulse in the next cycle with din_reg complete, and the FSM SHALL enter DONE.
REQ-022 In RD_WAIT, rd_req SHALL be 1; in the cycle rd_ack=1 the block SHALL capture rd_data, drop rd_req and enter RD_SHIFT.
REQ-023 In RD_SHIFT, the block SHALL drive sdo = captured bit k with sdo_valid=1 in the k-th cycle (k=0..DATA_W-1), then enter DONE with sdo=0 and sdo_valid=0.
REQ-024 DONE SHALL hold until lad=00 and then return to IDLE; a held non-00 lad SHALL NOT restart an operation.
REQ-025 lad=00 in any state SHALL force IDLE next cycle, without wr_en, with rd_req dropped and sdo/sdo_valid zeroed; addr_reg and din_reg SHALL keep their partial contents.
REQ-026 A lad value differing from the entry mode in a busy state SHALL abort to IDLE as in REQ-025, and err SHALL pulse.
REQ-027 rd_ack outside RD_WAIT SHALL be ignored.
REQ-028 The bit counter SHALL be $clog2(DATA_W+2) bits wide and SHALL never wrap.

Reset
REQ-029 Asserted rst SHALL immediately force IDLE and zero addr_reg, din_reg, counter, capture register and all outputs, including during any operation.

Configuration
REQ-030 With SIO_PARITY_EN defined, LOAD_D SHALL take DATA_W+1 bits, the last being even parity over the word; on a match wr_en SHALL pulse, otherwise err SHALL pulse instead of wr_en.
REQ-031 With SIO_PARITY_EN defined, RD_SHIFT SHALL emit a (DATA_W+1)-th bit carrying even parity, with sdo_valid=1.
REQ-032 Without SIO_PARITY_EN, no parity logic SHALL exist, and err SHALL pulse only per REQ-026.

Structure
REQ-033 The lad mode encoding and state enumeration SHALL live in package sio_pkg.
REQ-034 The LSB-first shifter with bit counter and done flag SHALL be a sub-module sio_shift_in, instantiated once for address and once for data.

Verification
REQ-035 Address load: lad=01, shift 10'h2A5 LSB first -> addr_reg=10'h2A5 after 10 bits, DONE; extra bits ignored.
REQ-036 Data write: lad=10, shift 64'hDEADBEEF_01234567 -> wr_en high exactly one cycle after bit 63, din_reg equal to the word.
REQ-037 Read: lad=11, rd_ack asserted 3 cycles after rd_req, rd_data=64'h8000_0000_0000_0001 -> sdo 1,0...0,1 over 64 sdo_valid cycles.
REQ-038 Abort: lad 10 -> 00 after 20 bits -> IDLE next cycle, no wr_en, din_reg holds the 20 shifted bits.
REQ-039 Reset in RD_SHIFT at bit 30 -> all outputs 0 immediately, busy=0.
REQ-040 SIO_PARITY_EN: data word 64'h1 with parity bit 0 -> err pulse, no wr_en; with parity bit 1 -> wr_en pulse.
